// File: rtl/result_bcd_converter_if.sv
// ---------------------------------------------------------------------------
// result_bcd_converter_if
//
// Bundles the start/busy/done/valid handshake and the result buses between
// the LCD writer (master) and the binary-to-BCD converter (slave).
//
// Parameters:
//   WIDTH  - binary input width
//   DIGITS - number of decimal digits produced
//
// Signals:
//   start       master -> slave  conversion request
//   bin_in      master -> slave  unsigned value to convert
//   busy        slave -> master  conversion in progress
//   done        slave -> master  one-cycle pulse when results update
//   valid       slave -> master  results hold a completed conversion
//   bcd_out     slave -> master  packed BCD, units digit in [3:0]
//   ascii_out   slave -> master  one ASCII char per digit, units in [7:0]
//   digit_count slave -> master  number of significant digits
// ---------------------------------------------------------------------------
interface result_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                          start;
    logic [WIDTH-1:0]              bin_in;
    logic                          busy;
    logic                          done;
    logic                          valid;
    logic [4*DIGITS-1:0]           bcd_out;
    logic [8*DIGITS-1:0]           ascii_out;
    logic [$clog2(DIGITS+1)-1:0]   digit_count;

    modport master (
        output start, bin_in,
        input  busy, done, valid, bcd_out, ascii_out, digit_count
    );

    modport slave (
        input  start, bin_in,
        output busy, done, valid, bcd_out, ascii_out, digit_count
    );
endinterface

// File: rtl/result_bcd_converter.sv
// ---------------------------------------------------------------------------
// result_bcd_converter
//
// Sequential shift-and-add-3 (double-dabble) converter from the datapath's
// unsigned result register to decimal for the LCD. One input bit is consumed
// per clock; after WIDTH shifts the BCD digits, LCD-ready ASCII characters
// (leading zeros blanked to spaces, units digit always shown) and the
// significant-digit count are registered and a done pulse is issued.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - result_bcd_converter_if.slave (start/bin_in in, results out)
// ---------------------------------------------------------------------------
module result_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    result_bcd_converter_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DC_W  = $clog2(DIGITS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]          state;
    logic [WIDTH-1:0]    shift_reg;
    logic [4*DIGITS-1:0] scratch;
    logic [CNT_W-1:0]    bit_cnt;

    logic                done_r;
    logic                valid_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [8*DIGITS-1:0] ascii_r;
    logic [DC_W-1:0]     count_r;

    logic [4*DIGITS-1:0] adjusted;
    logic [8*DIGITS-1:0] ascii_next;
    logic [DC_W-1:0]     count_next;

    // Add-3 correction on the pre-shift digits, so that after the left shift
    // no digit can exceed 9.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Formatting of the finished scratch digits. The highest nonzero digit
    // sets both the digit count and the blanking boundary; an all-zero value
    // leaves the boundary at the units digit so "0" is still displayed.
    always_comb begin
        int msd;
        msd        = 0;
        ascii_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] != 4'd0)
                msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (i > msd)
                ascii_next[8*i +: 8] = 8'h20;
            else
                ascii_next[8*i +: 8] = 8'h30 + {4'h0, scratch[4*i +: 4]};
        end
        count_next = DC_W'(msd + 1);
    end

    // Control FSM and datapath. Results are only written in FINISH so they
    // hold their previous values throughout a new conversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            done_r    <= 1'b0;
            valid_r   <= 1'b0;
            bcd_r     <= '0;
            ascii_r   <= {DIGITS{8'h20}};
            count_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        shift_reg <= bus.bin_in;
                        scratch   <= '0;
                        bit_cnt   <= CNT_W'(WIDTH);
                        valid_r   <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {scratch, shift_reg} <= {adjusted, shift_reg} << 1;
                    bit_cnt              <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1))
                        state <= ST_FINISH;
                end
                ST_FINISH: begin
                    bcd_r   <= scratch;
                    ascii_r <= ascii_next;
                    count_r <= count_next;
                    valid_r <= 1'b1;
                    done_r  <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = done_r;
    assign bus.valid       = valid_r;
    assign bus.bcd_out     = bcd_r;
    assign bus.ascii_out   = ascii_r;
    assign bus.digit_count = count_r;

endmodule

// File: doc/result_bcd_converter.md
# result_bcd_converter

Sequential binary-to-decimal converter between the exponent datapath's 16-bit result register and the LCD controller. On a start pulse it captures the unsigned result and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents packed BCD digits, LCD-ready ASCII characters with leading-zero blanking, and a significant-digit count. The LCD writer consumes these through a start/busy/done/valid handshake.

## Interface
- WIDTH, 16, binary input width (unsigned).
- DIGITS, 5, decimal digits produced; must satisfy 10^DIGITS > 2^WIDTH − 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- start  input  1  request; accepted only when busy=0.
- bin_in  input  WIDTH  value to convert (output_reg of the datapath); sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when results update.
- valid  output  1  level; results hold a completed conversion.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- ascii_out  output  8*DIGITS  one character per digit; units char in [7:0].
- digit_count  output  $clog2(DIGITS+1)  significant digits, 1..DIGITS.

## Operation
- States:
  - IDLE: start=1 → load shift register with bin_in, clear the BCD scratch, load the bit counter with WIDTH, clear valid, go to SHIFT.
  - SHIFT: each cycle, every scratch digit ≥5 gets +3. The {scratch, shift} concatenation then shifts left 1 (MSB of shift enters scratch digit 0 LSB). Decrement the counter. After the WIDTH-th shift, go to FINISH.
  - FINISH: register bcd_out, ascii_out and digit_count; set valid=1; pulse done; go to IDLE.
- Adjust and shift occur in the same cycle. Adjust is applied to the pre-shift digits; no digit ever exceeds 9 after the shift.
- ASCII: a digit becomes 8'h30+digit. Leading zeros above the most significant nonzero digit become 8'h20. The units digit is never blanked, so value 0 gives "    0".
- digit_count = index of the most significant nonzero digit + 1; value 0 gives 1.
- start while busy=1 (SHIFT/FINISH) is ignored, and bin_in changes during a conversion have no effect.
- Outputs bcd_out/ascii_out/digit_count change only in FINISH. Between conversions they hold their last values, including while valid=0 during a new conversion.
- Reset (async, any state): state IDLE, busy=0, done=0, valid=0, bcd_out=0, ascii_out all 8'h20, digit_count=0, scratch/counter cleared. An in-flight conversion is discarded.

## Timing
- Edge E0: start accepted in IDLE. busy=1 and valid=0 from E0.
- Edges E1..E(WIDTH): shifts (16 for default).
- Edge E(WIDTH+1): outputs registered; done=1 and valid=1 for the following cycle; busy=0.
- Latency from the accepting edge to done is WIDTH+1 cycles (17 default). Throughput is one conversion per WIDTH+2 cycles.
- busy = (state ≠ IDLE); it is combinational from state and has no glitch requirements beyond that.
- done is high exactly one cycle per conversion and never during reset.
- Back-to-back: start high in the cycle where done=1 is accepted at the next edge. valid then drops at that edge and done deasserts.
- Reset deassertion is synchronised externally. The first edge after release may accept start.

## Test plan
- Reset, then bin_in=0, start pulse → after 17 cycles: done pulse, bcd_out=20'h00000, ascii_out="    0" (20 20 20 20 30), digit_count=1, valid=1.
- bin_in=16'hFFFF → bcd_out=20'h65535, ascii_out="65535", digit_count=5. The done pulse is exactly 1 cycle wide and busy is high for exactly 17 cycles.
- bin_in=1024 (e.g. 2^10 from the datapath), then bin_in=9999, then bin_in=10 → " 1024"/4, " 9999"/4, "   10"/2. bcd_out=20'h01024, 20'h09999, 20'h00010.
- Start 1234. Toggle start and change bin_in to 777 at cycles 3 and 9 of the conversion → only "1234" produced, one done pulse, no second conversion.
- Start 500, assert rst at cycle 8 → all outputs at reset values immediately (asynchronous); no done pulse. After release, start 42 → "   42", digit_count=2.
- Hold start=1 continuously with bin_in=3 then 65000 on alternate conversions → a done pulse every 18 cycles. valid drops for the 17 busy cycles. Results alternate "    3"/"65000" with no missed or corrupted conversion.
